// File: rtl/dataframe_capture_ctrl.sv
// Capture sequencer for lpGBT uplink frames into the dataframe buffer (clk40 domain).
// Arms from software, waits for an immediate or pattern trigger, then writes N consecutive valid frames.
module dataframe_capture_ctrl #(
    parameter int DATA_W = 234,
    parameter int ADDR_W = 10,
    parameter int TRIG_W = 16
) (
    input  logic              clk40_i,
    input  logic              aresetn_i,
    input  logic [DATA_W-1:0] uplinkUserData_i,
    input  logic              uplinkrdy_i,
    input  logic              uplinkFEC_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              trig_mode_i,
    input  logic [TRIG_W-1:0] trig_pattern_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [ADDR_W:0]   n_frames_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic [ADDR_W:0]   frames_stored_o,
    output logic [15:0]       fec_err_cnt_o,
    output logic              link_lost_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    // A zero or oversized request means "fill the whole buffer".
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        logic [ADDR_W:0] r;
        if ((n == {(ADDR_W+1){1'b0}}) || (n > DEPTH_C)) begin
            r = DEPTH_C;
        end else begin
            r = n;
        end
        return r;
    endfunction

    function automatic logic pattern_hit(input logic [TRIG_W-1:0] d,
                                         input logic [TRIG_W-1:0] p,
                                         input logic [TRIG_W-1:0] m);
        return (((d ^ p) & m) == {TRIG_W{1'b0}});
    endfunction

    state_t              state_r, state_nxt_s;
    logic [ADDR_W:0]     n_lat_r;
    logic                mode_r;
    logic [ADDR_W:0]     frames_r;
    logic [15:0]         fec_r;
    logic                lost_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                valid_s, trig_s, arm_s, store_s, last_s;
    logic [1:0]          state_s;
    logic                done_s;

    // Trigger, arm and store qualifiers; abort overrides everything.
    always_comb begin
        valid_s = uplinkrdy_i;
        trig_s  = mode_r ? (valid_s && pattern_hit(uplinkUserData_i[TRIG_W-1:0], trig_pattern_i, trig_mask_i))
                         : valid_s;
        arm_s   = arm_i && !abort_i && ((state_r == S_IDLE) || (state_r == S_DONE));
        store_s = !abort_i && (((state_r == S_ARMED) && trig_s) || ((state_r == S_CAPTURE) && valid_s));
        last_s  = store_s && ((frames_r + {{ADDR_W{1'b0}}, 1'b1}) == n_lat_r);
    end

    // State register.
    always_ff @(posedge clk40_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (arm_s) state_nxt_s = S_ARMED;
                else       state_nxt_s = S_IDLE;
            end
            S_ARMED: begin
                if (abort_i)      state_nxt_s = S_IDLE;
                else if (last_s)  state_nxt_s = S_DONE;
                else if (store_s) state_nxt_s = S_CAPTURE;
                else              state_nxt_s = S_ARMED;
            end
            S_CAPTURE: begin
                if (abort_i)     state_nxt_s = S_IDLE;
                else if (last_s) state_nxt_s = S_DONE;
                else             state_nxt_s = S_CAPTURE;
            end
            S_DONE: begin
                if (abort_i)    state_nxt_s = S_IDLE;
                else if (arm_s) state_nxt_s = S_ARMED;
                else            state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        state_s = state_r;
        done_s  = (state_r == S_DONE);
    end

    // Capture datapath: write port registers and status counters.
    always_ff @(posedge clk40_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            n_lat_r  <= {(ADDR_W+1){1'b0}};
            mode_r   <= 1'b0;
            frames_r <= {(ADDR_W+1){1'b0}};
            fec_r    <= 16'h0000;
            lost_r   <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
        end else begin
            we_r <= store_s;
            if (arm_s) begin
                n_lat_r  <= clamp_count(n_frames_i);
                mode_r   <= trig_mode_i;
                frames_r <= {(ADDR_W+1){1'b0}};
                fec_r    <= 16'h0000;
                lost_r   <= 1'b0;
                addr_r   <= {ADDR_W{1'b0}};
            end else if (store_s) begin
                frames_r <= frames_r + {{ADDR_W{1'b0}}, 1'b1};
                addr_r   <= frames_r[ADDR_W-1:0];
                wdata_r  <= uplinkUserData_i;
                if (uplinkFEC_i && (fec_r != 16'hFFFF)) fec_r <= fec_r + 16'h0001;
                else                                    fec_r <= fec_r;
            end else begin
                if (!abort_i && (state_r == S_CAPTURE) && !valid_s) lost_r <= 1'b1;
                else                                               lost_r <= lost_r;
            end
        end
    end

    assign mem_we_o        = we_r;
    assign mem_addr_o      = addr_r;
    assign mem_wdata_o     = wdata_r;
    assign state_o         = state_s;
    assign done_o          = done_s;
    assign frames_stored_o = frames_r;
    assign fec_err_cnt_o   = fec_r;
    assign link_lost_o     = lost_r;

endmodule

// File: doc/dataframe_capture_ctrl.md
Name: dataframe_capture_ctrl

Overview:
Sequences capture of lpGBT uplink frames into the dataframe buffer memory.
- Software arms it via already-synchronised clk40 control signals.
- It waits for an immediate or pattern-match trigger, then writes a programmed number of consecutive valid frames at incrementing addresses.
- It reports progress, completion, FEC errors and link loss.
- It sits between the lpGBT uplink and the buffer's write port, in the clk40 domain.

Parameters:
- DATA_W, 234, uplink user-data width.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W frames.
- TRIG_W, 16, width of the trigger compare field (uplinkUserData_i[TRIG_W-1:0]).

Ports:
- clk40_i  in  1  uplink frame clock; the only clock.
- aresetn_i  in  1  asynchronous active-low reset.
- uplinkUserData_i  in  DATA_W  uplink frame data.
- uplinkrdy_i  in  1  uplink locked/frame valid.
- uplinkFEC_i  in  1  FEC-corrected error flag for the current frame.
- arm_i  in  1  single-cycle pulse: start a capture.
- abort_i  in  1  single-cycle pulse: cancel the capture.
- trig_mode_i  in  1  0 = trigger on the first valid frame, 1 = pattern match.
- trig_pattern_i  in  TRIG_W  pattern to match.
- trig_mask_i  in  TRIG_W  1 = bit compared.
- n_frames_i  in  ADDR_W+1  frames to store; 0 or >DEPTH is clamped to DEPTH.
- mem_we_o  out  1  buffer write enable.
- mem_addr_o  out  ADDR_W  buffer write address.
- mem_wdata_o  out  DATA_W  buffer write data.
- state_o  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
- done_o  out  1  level; high in DONE.
- frames_stored_o  out  ADDR_W+1  frames written in this capture.
- fec_err_cnt_o  out  16  saturating count of stored frames with FEC flag set.
- link_lost_o  out  1  sticky; uplinkrdy_i was low during CAPTURE.

Behaviour:
- Reset (async assert, sync release): state IDLE. mem_we_o, mem_addr_o, mem_wdata_o, done_o, frames_stored_o, fec_err_cnt_o and link_lost_o all 0.
- "valid" means uplinkrdy_i = 1.
- A pattern "match" requires valid, and ((uplinkUserData_i[TRIG_W-1:0] ^ trig_pattern_i) & trig_mask_i) == 0.
- IDLE -> ARMED on arm_i. On that edge:
  - latch the clamped n_frames_i and trig_mode_i;
  - clear frames_stored_o, fec_err_cnt_o, link_lost_o and the address.
- DONE -> ARMED on arm_i, with the same actions; done_o drops in the same cycle the state leaves DONE.
- arm_i in ARMED or CAPTURE is ignored.
- ARMED -> CAPTURE on the first cycle where the trigger condition holds:
  - mode 0: valid;
  - mode 1: match.
- The trigger frame itself is stored as frame 0.
- CAPTURE, each cycle with valid (including the trigger cycle):
  - store the frame;
  - frames_stored_o += 1;
  - if uplinkFEC_i = 1, fec_err_cnt_o += 1, saturating at 0xFFFF.
- CAPTURE with uplinkrdy_i low: no write, no count, link_lost_o set (sticky until next arm).
- Write timing:
  - data registered: frame sampled at edge t appears on mem_wdata_o with mem_we_o = 1 and mem_addr_o = index during cycle t+1;
  - mem_we_o is a one-cycle pulse per stored frame;
  - the address increments after each write and never wraps within one capture.
- CAPTURE -> DONE on the cycle the final frame is sampled (frames_stored reaches the latched count); the last write still occurs in the following cycle.
- abort_i from any state -> IDLE next cycle:
  - a write already registered completes;
  - no further writes;
  - done_o stays 0;
  - status counters hold their values.
- abort_i and arm_i together: abort wins.
- Reset mid-capture: immediate return to the reset values; no write pulse.
- Counter width: frames_stored_o spans 0..DEPTH inclusive (ADDR_W+1 bits).

Test Plan:
- Reset, then arm_i with trig_mode_i = 0, n_frames_i = 4, uplinkrdy_i = 1, data = 0..3 -> writes to addr 0..3 with data 0..3, one cycle after each sample; done_o = 1; frames_stored_o = 4; state_o = 11.
- Mode 1, pattern 0x00A5, mask 0x00FF, frames with low byte 0x10, 0x11, 0x12A5, 0x13 -> first write is 0x12A5 at addr 0; subsequent frames follow at addr 1, 2...
- n_frames_i = 6 with uplinkrdy_i low for 2 cycles mid-capture -> exactly 6 writes at addresses 0..5, no gaps; link_lost_o = 1.
- n_frames_i = 0 with continuous valid frames -> 1024 writes; addr ends at 0x3FF; frames_stored_o = 1024.
- uplinkFEC_i high on frames 1 and 3 of 5 -> fec_err_cnt_o = 2; a second arm clears it to 0.
- abort_i after 2 writes of 8, plus arm_i and abort_i asserted together in ARMED -> state_o = 00; frames_stored_o = 2; no later mem_we_o; done_o = 0.
